// File: rtl/fpga_config_loader.sv
// Bitstream loader: framed byte stream with an XOR checksum into the fabric's config selects.
// Ports: clk/rst, in_data/in_valid/in_ready stream, cfg_abort, select buses, busy/cfg_done/configured/cfg_err.
module fpga_config_loader #(
    parameter int          BRB_W     = 900,
    parameter int          BSB_W     = 1728,
    parameter int          LB_W      = 80,
    parameter int          IO_W      = 30,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              cfg_abort,
    output logic [BRB_W-1:0]  brbselect,
    output logic [BSB_W-1:0]  bsbselect,
    output logic [LB_W-1:0]   lbselect,
    output logic [IO_W-1:0]   leftioselect,
    output logic [IO_W-1:0]   rightioselect,
    output logic [IO_W-1:0]   topioselect,
    output logic [IO_W-1:0]   bottomioselect,
    output logic              busy,
    output logic              cfg_done,
    output logic              configured,
    output logic              cfg_err
);
    localparam int TOTAL  = BRB_W + BSB_W + LB_W + 4 * IO_W;
    localparam int NBYTES = (TOTAL + 7) / 8;
    localparam int CW     = $clog2(NBYTES + 1);
    localparam int IW     = $clog2(TOTAL + 8);
    localparam int LB_O   = BRB_W + BSB_W;
    localparam int IO_O   = LB_O + LB_W;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [7:0]        xr;
    logic [TOTAL-1:0]  stg;
    logic [TOTAL-1:0]  active;
    logic              take;
    logic [IW-1:0]     base;

    assign in_ready = ~rst & (state != COMMIT);
    assign take     = in_valid & in_ready;
    assign busy     = (state == LOAD) | (state == CHECK);
    assign cfg_done = (state == COMMIT);
    assign base     = IW'({cnt, 3'b000});

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (take && in_data == SYNC_BYTE) state_nx = LOAD;
            LOAD: begin
                if (cfg_abort)
                    state_nx = IDLE;
                else if (take && cnt == CW'(NBYTES - 1))
                    state_nx = CHECK;
            end
            CHECK: begin
                if (cfg_abort)
                    state_nx = IDLE;
                else if (take)
                    state_nx = (in_data == xr) ? COMMIT : IDLE;
            end
            COMMIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            xr         <= '0;
            stg        <= '0;
            active     <= '0;
            configured <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take && in_data == SYNC_BYTE) begin
                        cnt     <= '0;
                        xr      <= '0;
                        cfg_err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!cfg_abort && take) begin
                        // last byte carries padding past TOTAL; drop those bits
                        for (int i = 0; i < 8; i++)
                            if (int'(base) + i < TOTAL)
                                stg[base + IW'(i)] <= in_data[i];
                        xr  <= xr ^ in_data;
                        cnt <= cnt + CW'(1);
                    end
                end
                CHECK: begin
                    if (!cfg_abort && take && in_data != xr)
                        cfg_err <= 1'b1;
                end
                COMMIT: begin
                    active     <= stg;
                    configured <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign brbselect      = active[BRB_W-1:0];
    assign bsbselect      = active[BRB_W +: BSB_W];
    assign lbselect       = active[LB_O +: LB_W];
    assign leftioselect   = active[IO_O +: IO_W];
    assign rightioselect  = active[IO_O + IO_W +: IO_W];
    assign topioselect    = active[IO_O + 2 * IO_W +: IO_W];
    assign bottomioselect = active[IO_O + 3 * IO_W +: IO_W];
endmodule

// File: tb/tb_fpga_config_loader.sv
// Randomized stream bench for fpga_config_loader with a byte-queue frame model.
// Compares every output on every falling edge, plus literal spot checks.
module tb_fpga_config_loader;
    localparam int TOTAL  = 2828;
    localparam int NB     = 354;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         cfg_abort = 1'b0;
    logic [899:0] brbselect;
    logic [1727:0] bsbselect;
    logic [79:0]  lbselect;
    logic [29:0]  leftioselect, rightioselect, topioselect, bottomioselect;
    logic         busy, cfg_done, configured, cfg_err;

    int checks = 0;
    int errors = 0;

    fpga_config_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cfg_abort(cfg_abort),
        .brbselect(brbselect), .bsbselect(bsbselect), .lbselect(lbselect),
        .leftioselect(leftioselect), .rightioselect(rightioselect),
        .topioselect(topioselect), .bottomioselect(bottomioselect),
        .busy(busy), .cfg_done(cfg_done), .configured(configured),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // model: phase 0 hunting sync, 1 payload, 2 checksum, 3 commit
    int              m_phase = 0;
    logic [7:0]      pl [$];
    logic [7:0]      m_stg [NB];
    logic [TOTAL-1:0] m_active = '0;
    bit              m_conf = 0;
    bit              m_err = 0;
    logic [7:0]      fr [NB];

    task automatic cmp(string nm, logic [1727:0] got, logic [1727:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got[63:0]=%h want[63:0]=%h", nm, got[63:0], want[63:0]);
        end
    endtask

    function automatic logic [7:0] q_xor();
        logic [7:0] x = 8'h00;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    function automatic logic [7:0] fr_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < NB; i++) x ^= fr[i];
        return x;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        pl.delete();
        for (int i = 0; i < NB; i++) m_stg[i] = 8'h00;
        m_active = '0;
        m_conf = 0;
        m_err = 0;
    endtask

    task automatic model_update(bit v, logic [7:0] d, bit ab);
        case (m_phase)
            0: if (v && d == 8'hA5) begin
                m_phase = 1;
                pl.delete();
                m_err = 0;
            end
            1: if (ab) m_phase = 0;
               else if (v) begin
                   m_stg[pl.size()] = d;
                   pl.push_back(d);
                   if (pl.size() == NB) m_phase = 2;
               end
            2: if (ab) m_phase = 0;
               else if (v) begin
                   if (d == q_xor()) m_phase = 3;
                   else begin
                       m_err = 1;
                       m_phase = 0;
                   end
               end
            default: begin
                for (int i = 0; i < TOTAL; i++) m_active[i] = m_stg[i / 8][i % 8];
                m_conf = 1;
                m_phase = 0;
            end
        endcase
    endtask

    always @(negedge clk) begin
        cmp("in_ready", 1728'(in_ready), 1728'(!rst && m_phase != 3));
        cmp("busy", 1728'(busy), 1728'(m_phase == 1 || m_phase == 2));
        cmp("cfg_done", 1728'(cfg_done), 1728'(m_phase == 3));
        cmp("configured", 1728'(configured), 1728'(m_conf));
        cmp("cfg_err", 1728'(cfg_err), 1728'(m_err));
        cmp("brb", 1728'(brbselect), 1728'(m_active[899:0]));
        cmp("bsb", bsbselect, m_active[2627:900]);
        cmp("lb", 1728'(lbselect), 1728'(m_active[2707:2628]));
        cmp("leftio", 1728'(leftioselect), 1728'(m_active[2737:2708]));
        cmp("rightio", 1728'(rightioselect), 1728'(m_active[2767:2738]));
        cmp("topio", 1728'(topioselect), 1728'(m_active[2797:2768]));
        cmp("bottomio", 1728'(bottomioselect), 1728'(m_active[2827:2798]));
    end

    task automatic step(bit v, logic [7:0] d, bit ab, output bit acc);
        in_valid = v;
        in_data = d;
        cfg_abort = ab;
        @(posedge clk);
        acc = v && !rst && m_phase != 3;
        if (!rst) model_update(v, d, ab);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        cfg_abort = 1'b0;
    endtask

    task automatic idle(int n);
        bit a;
        repeat (n) step(0, 8'h00, 0, a);
    endtask

    task automatic send_byte(logic [7:0] b, int gap);
        bit a = 0;
        int tries = 0;
        idle($urandom_range(0, gap));
        while (!a) begin
            step(1, b, 0, a);
            tries++;
            if (!a && tries > 8) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout got=0 want=1");
                a = 1;
            end
        end
    endtask

    task automatic send_frame(logic [7:0] ck, int gap);
        send_byte(8'hA5, gap);
        for (int i = 0; i < NB; i++) send_byte(fr[i], gap);
        send_byte(ck, gap);
    endtask

    task automatic rand_fr();
        for (int i = 0; i < NB; i++) fr[i] = 8'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle(3);
        rst = 1'b0;
        idle(2);
        cmp("rst_ready", 1728'(in_ready), 1728'(1'b1));

        // single LSB set in routing box; check commit latency
        for (int i = 0; i < NB; i++) fr[i] = 8'h00;
        fr[0] = 8'h01;
        send_frame(8'h01, 0);
        cmp("lit_done_pulse", 1728'(cfg_done), 1728'(1'b1));
        cmp("lit_brb_before", 1728'(brbselect), 1728'(0));
        idle(1);
        cmp("lit_done_low", 1728'(cfg_done), 1728'(1'b0));
        cmp("lit_brb_after", 1728'(brbselect), 1728'(1));
        cmp("lit_configured", 1728'(configured), 1728'(1'b1));

        // last byte all ones: only bottomio[29:26], padding dropped
        for (int i = 0; i < NB; i++) fr[i] = 8'h00;
        fr[NB-1] = 8'hFF;
        send_frame(8'hFF, 1);
        idle(1);
        cmp("lit_bottomio", 1728'(bottomioselect), 1728'(30'h3C000000));
        cmp("lit_brb_cleared", 1728'(brbselect), 1728'(0));

        // random valid frame, then frame with wrong checksum
        rand_fr();
        send_frame(fr_xor(), 2);
        rand_fr();
        fr[NB-1] = 8'h00;
        fr[NB-1] = fr_xor() ^ 8'h5A;
        send_frame(8'h00, 1);
        idle(1);
        cmp("lit_err_set", 1728'(cfg_err), 1728'(1'b1));
        send_byte(8'hA5, 0);
        cmp("lit_err_clear", 1728'(cfg_err), 1728'(1'b0));

        // abort after 100 payload bytes
        for (int i = 0; i < 100; i++) send_byte(8'($urandom), 1);
        begin
            bit a;
            step(0, 8'h00, 1, a);
        end
        cmp("lit_abort_busy", 1728'(busy), 1728'(1'b0));
        rand_fr();
        send_frame(fr_xor(), 2);
        idle(1);

        // junk ahead, sync values inside payload, back-to-back frames
        send_byte(8'h3C, 0);
        send_byte(8'h3C, 0);
        rand_fr();
        for (int i = 0; i < 12; i++) fr[$urandom_range(0, NB - 1)] = 8'hA5;
        send_frame(fr_xor(), 3);
        rand_fr();
        send_frame(fr_xor(), 0);
        idle(2);

        // reset mid-load: outputs clear without a clock edge
        send_byte(8'hA5, 0);
        for (int i = 0; i < 50; i++) send_byte(8'($urandom), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        cmp("lit_rst_brb", 1728'(brbselect), 1728'(0));
        cmp("lit_rst_bsb", bsbselect, 1728'(0));
        cmp("lit_rst_busy", 1728'(busy), 1728'(1'b0));
        cmp("lit_rst_conf", 1728'(configured), 1728'(1'b0));
        cmp("lit_rst_ready", 1728'(in_ready), 1728'(1'b0));
        idle(2);
        rst = 1'b0;
        idle(1);
        rand_fr();
        send_frame(fr_xor(), 1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
